// File: rtl/rep3_serial_tx.sv
// Serial repetition-code transmitter: shifts a parallel word out LSB-first,
// sending every bit REP times back to back so a majority voter can recover it.
module rep3_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_frame,
  output logic              tx_done
);

  localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_frame_q, tx_frame_d;
  logic              tx_done_q, tx_done_d;

  assign in_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d   = in_data;
          bit_idx_d = '0;
          rep_cnt_d = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          // Terminal bit: leave the index at zero instead of letting it wrap.
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so the first copy appears
    // in the cycle right after the acceptance edge.
    tx_frame_d = (state_d == S_SEND);
    tx_bit_d   = tx_frame_d & shreg_d[0];
    tx_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      rep_cnt_q  <= '0;
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign tx_frame = tx_frame_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed + randomized bench for rep3_serial_tx; expected streams come from
// the rule "copy k of the frame is word bit k/REP", plus a majority-vote decode.
module tb_rep3_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, tx_bit, tx_frame, tx_done;

  logic [3:0] in_data2;
  logic       in_valid2;
  logic       in_ready2, tx_bit2, tx_frame2, tx_done2;

  logic sel;
  logic m_frame, m_bit, m_done, m_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit cap [0:63];

  always #5 clk = ~clk;

  rep3_serial_tx #(.DATA_W(8), .REP(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_bit(tx_bit), .tx_frame(tx_frame), .tx_done(tx_done)
  );

  rep3_serial_tx #(.DATA_W(4), .REP(5)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx_bit(tx_bit2), .tx_frame(tx_frame2), .tx_done(tx_done2)
  );

  always_comb begin
    m_frame = sel ? tx_frame2 : tx_frame;
    m_bit   = sel ? tx_bit2   : tx_bit;
    m_done  = sel ? tx_done2  : tx_done;
    m_ready = sel ? in_ready2 : in_ready;
  end

  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the handshake already presented; returns at the
  // IDLE negedge after the DONE pulse. Drives mid_data/valid during the frame.
  task automatic check_frame(input logic [31:0] w, input int dw, input int rep,
                             input bit keep_valid, input logic [7:0] mid_data,
                             input string tag);
    bit exp_q[$];
    int waits;
    for (int i = 0; i < dw; i++)
      for (int r = 0; r < rep; r++)
        exp_q.push_back(w[i]);
    waits = 0;
    @(negedge clk);
    while (!m_frame && waits < 8) begin
      waits++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(waits), 32'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s_frame%0d", tag, k), 32'(m_frame), 32'd1);
      chk($sformatf("%s_bit%0d", tag, k), 32'(m_bit), 32'(exp_q[k]));
      chk($sformatf("%s_ready%0d", tag, k), 32'(m_ready), 32'd0);
      cap[k] = m_bit;
      if (k == 0) begin
        if (sel) begin in_data2 = mid_data[3:0]; in_valid2 = 1'b1; end
        else     begin in_data  = mid_data;      in_valid  = 1'b1; end
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(m_done), 32'd1);
    chk({tag, "_done_frame"}, 32'(m_frame), 32'd0);
    chk({tag, "_done_bit"}, 32'(m_bit), 32'd0);
    if (!keep_valid) begin in_valid = 1'b0; in_valid2 = 1'b0; end
    @(negedge clk);
    chk({tag, "_idle_done"}, 32'(m_done), 32'd0);
    chk({tag, "_idle_frame"}, 32'(m_frame), 32'd0);
    chk({tag, "_idle_ready"}, 32'(m_ready), 32'd1);
  endtask

  // Corrupts one random copy per group of three, then majority-votes each group.
  function automatic logic [7:0] vote_decode();
    logic [7:0] rec;
    bit g [0:2];
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 3; r++) g[r] = cap[3*i + r];
      g[$urandom_range(0, 2)] ^= 1'b1;
      rec[i] = (g[0] & g[1]) | (g[0] & g[2]) | (g[1] & g[2]);
    end
    return rec;
  endfunction

  initial begin
    int d0;
    logic [7:0] w;
    sel = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    in_valid2 = 1'b0; in_data2 = 4'h0;

    // Reset held with a pending word.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_frame", 32'(tx_frame), 32'd0);
      chk("rst_bit", 32'(tx_bit), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_frame", 32'(tx_frame), 32'd0);
    end

    // Single word.
    in_valid = 1'b1; in_data = 8'hA5;
    check_frame(32'hA5, 8, 3, 1'b0, 8'h5A, "a5");

    // Back-to-back with valid held high.
    d0 = done_cnt;
    in_valid = 1'b1; in_data = 8'h01;
    check_frame(32'h01, 8, 3, 1'b1, 8'h80, "b2b_01");
    check_frame(32'h80, 8, 3, 1'b0, 8'h80, "b2b_80");
    @(negedge clk);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Inputs changed during SEND are ignored.
    in_valid = 1'b1; in_data = 8'h0F;
    check_frame(32'h0F, 8, 3, 1'b0, 8'hF0, "ign");

    // Reset mid-frame.
    d0 = done_cnt;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_start", 32'(tx_frame), 32'd1);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("abort_bit%0d", k), 32'(tx_bit), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_frame", 32'(tx_frame), 32'd0);
    chk("abort_bit", 32'(tx_bit), 32'd0);
    chk("abort_done", 32'(tx_done), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_frame", 32'(tx_frame), 32'd0);
    chk("abort_idle_ready", 32'(in_ready), 32'd1);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    in_valid = 1'b1; in_data = 8'h00;
    check_frame(32'h00, 8, 3, 1'b0, 8'hFF, "clean00");

    // Parameter variant DATA_W=4, REP=5.
    sel = 1'b1;
    in_valid2 = 1'b1; in_data2 = 4'b1010;
    check_frame(32'hA, 4, 5, 1'b0, 8'h05, "v45");
    sel = 1'b0;

    // Voter loopback on a fixed word, then on random words.
    in_valid = 1'b1; in_data = 8'h3C;
    check_frame(32'h3C, 8, 3, 1'b0, 8'hC3, "vote3c");
    chk("vote3c_recovered", 32'(vote_decode()), 32'h3C);
    for (int n = 0; n < 6; n++) begin
      w = 8'($urandom);
      in_valid = 1'b1; in_data = w;
      check_frame(32'(w), 8, 3, 1'b0, 8'($urandom), $sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d_recovered", n), 32'(vote_decode()), 32'(w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
Serial repetition-code transmitter. It accepts a parallel data word through a valid/ready handshake and shifts it out LSB-first, one bit per clock, with each bit repeated REP consecutive times. It is the encoding end of the link whose receive side recovers each bit with a 3-input majority voter. A voter-based receiver therefore corrects any single corrupted copy per bit group.

Parameters:
DATA_W, 8, width of the parallel input word (>= 1)
REP, 3, number of copies sent per data bit (odd, >= 3)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
tx_bit  output  1  serial coded bit
tx_frame  output  1  high on every cycle tx_bit carries frame data
tx_done  output  1  one-cycle pulse after the last copy of the last bit

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high, sampled on the rising edge of clk, and has priority over all other inputs.
- Reset values: state=IDLE, tx_bit=0, tx_frame=0, tx_done=0, shift register=0, bit_idx=0, rep_cnt=0.
- in_ready is a combinational decode of state: 1 only in IDLE and when rst=0.
- tx_bit, tx_frame and tx_done are registered.
- States:
  - IDLE: tx_frame=0, tx_bit=0. A transfer is accepted on the edge where in_valid=1 and in_ready=1. On acceptance: latch in_data into shreg, bit_idx=0, rep_cnt=0, go to SEND.
  - SEND: tx_frame=1, tx_bit=shreg[0]. On each edge rep_cnt increments. When rep_cnt==REP-1: rep_cnt<=0, shreg shifts right by 1, bit_idx increments. When bit_idx==DATA_W-1 and rep_cnt==REP-1, go to DONE.
  - DONE: tx_frame=0, tx_bit=0, tx_done=1 for exactly this one cycle, then go to IDLE.
- Latency: the first copy of bit 0 appears on tx_bit in the cycle immediately after the acceptance edge.
- Frame length: exactly DATA_W*REP cycles with tx_frame=1 and no gaps.
- Throughput: one word per DATA_W*REP+2 cycles (SEND + DONE + IDLE acceptance cycle).
- Counter widths: rep_cnt is $clog2(REP) bits; bit_idx is $clog2(DATA_W) bits, minimum 1. Neither counter may wrap mid-frame. Terminal compares use the equalities above, never overflow.
- Input changes during SEND or DONE have no effect: in_valid and in_data are ignored and the latched word is transmitted unchanged.
- in_valid held high continuously: the next word is accepted in the IDLE cycle after DONE.
- Reset mid-frame: the frame aborts on the next edge. All outputs return to their reset values, no tx_done pulse is issued, and the partial frame is discarded.
- in_valid=1 while rst=1: the word is not accepted.
- The block contains no parity, start bit or stop bit. Framing is carried solely by tx_frame.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1, in_data=8'hFF -> in_ready=0, tx_frame=0, tx_bit=0, tx_done=0 throughout. After release, in_ready=1 and no frame starts without a new handshake.
2. Single word, defaults: send 8'hA5 -> starting the cycle after acceptance, 24 cycles with tx_frame=1 and tx_bit = 111 000 111 000 000 111 000 111. Then tx_done=1 for one cycle, then in_ready=1.
3. Back-to-back: in_valid held high with 8'h01 then 8'h80 -> first frame is 111 followed by 21 zeros. One DONE cycle and one IDLE cycle follow. Second frame is 21 zeros followed by 111. Exactly two tx_done pulses.
4. Input ignored mid-frame: accept 8'h0F, then drive in_data=8'hF0 and in_valid=1 during SEND -> transmitted bits still 12 ones then 12 zeros, and in_ready stays 0 until IDLE.
5. Reset mid-frame: accept 8'hFF, assert rst at cycle 10 of SEND -> on the next edge tx_frame=0, tx_bit=0, no tx_done. A later 8'h00 transmits a clean 24-zero frame.
6. Parameter variant and voter loopback: DATA_W=4, REP=5, send 4'b1010 -> 00000 11111 00000 11111 over 20 cycles. With REP=3, flip one copy per group of 8'h3C, feed the stream into a 3-input majority voter per group -> recovered word is 8'h3C.
